// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: PC/kill controller inputs, instruction-memory port and decode handshake.
interface fetch_stage_if #(
   parameter int AW = 12,
   parameter int IW = 16
);
   logic [AW-1:0] pc_in;
   logic [2:0]    kill_in;
   logic          pause_in;
   logic [AW-1:0] imem_addr;
   logic [IW-1:0] imem_rdata;
   logic          dec_valid;
   logic          dec_ready;
   logic [IW-1:0] dec_instr;
   logic [AW-1:0] dec_pc;
   logic          fetch_stall;
   logic          kill_ex;
   logic          ovf_err;

   modport slave (
      input  pc_in, kill_in, pause_in, imem_rdata, dec_ready,
      output imem_addr, dec_valid, dec_instr, dec_pc, fetch_stall, kill_ex, ovf_err
   );

   modport master (
      output pc_in, kill_in, pause_in, imem_rdata, dec_ready,
      input  imem_addr, dec_valid, dec_instr, dec_pc, fetch_stall, kill_ex, ovf_err
   );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: out register plus 1-entry skid for the 1-cycle-late imem response.
// Optional FETCH_PERF_EN adds saturating stall/kill performance counters.
module fetch_stage #(
   parameter int AW = 12,
   parameter int IW = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   fetch_stage_if.slave bus
`ifdef FETCH_PERF_EN
   ,
   output logic [15:0] perf_stall_cnt,
   output logic [15:0] perf_kill_cnt
`endif
);

   logic          fetch_stall_s, req_acc_s, resp_ok_s, fire_s;
   logic          req_live_q;
   logic [AW-1:0] req_pc_q;
   logic          dec_valid_q, dec_valid_d;
   logic [IW-1:0] dec_instr_q, dec_instr_d;
   logic [AW-1:0] dec_pc_q, dec_pc_d;
   logic          skid_valid_q, skid_valid_d;
   logic [IW-1:0] skid_instr_q, skid_instr_d;
   logic [AW-1:0] skid_pc_q, skid_pc_d;
   logic          kill_ex_q;
   logic          ovf_err_q, ovf_err_d;

   // Handshake terms; stall depends only on held state so the controller sees no pc_in loop
   always_comb begin
      fetch_stall_s = skid_valid_q | (dec_valid_q & ~bus.dec_ready);
      req_acc_s     = ~fetch_stall_s & ~bus.pause_in;
      resp_ok_s     = req_live_q & ~bus.kill_in[0];
      fire_s        = dec_valid_q & bus.dec_ready;
   end

   // Out/skid next state: flush first, then drain skid into out, else park response in skid
   always_comb begin
      dec_valid_d  = dec_valid_q;
      dec_instr_d  = dec_instr_q;
      dec_pc_d     = dec_pc_q;
      skid_valid_d = skid_valid_q;
      skid_instr_d = skid_instr_q;
      skid_pc_d    = skid_pc_q;
      ovf_err_d    = ovf_err_q;
      if (bus.kill_in[1]) begin
         skid_valid_d = 1'b0;
         dec_valid_d  = resp_ok_s;
         dec_instr_d  = resp_ok_s ? bus.imem_rdata : dec_instr_q;
         dec_pc_d     = resp_ok_s ? req_pc_q : dec_pc_q;
      end else if (!dec_valid_q || fire_s) begin
         if (skid_valid_q) begin
            dec_valid_d  = 1'b1;
            dec_instr_d  = skid_instr_q;
            dec_pc_d     = skid_pc_q;
            skid_valid_d = resp_ok_s;
            skid_instr_d = resp_ok_s ? bus.imem_rdata : skid_instr_q;
            skid_pc_d    = resp_ok_s ? req_pc_q : skid_pc_q;
         end else begin
            dec_valid_d  = resp_ok_s;
            dec_instr_d  = resp_ok_s ? bus.imem_rdata : dec_instr_q;
            dec_pc_d     = resp_ok_s ? req_pc_q : dec_pc_q;
         end
      end else begin
         if (resp_ok_s && skid_valid_q) begin
            ovf_err_d    = 1'b1;
         end else if (resp_ok_s) begin
            skid_valid_d = 1'b1;
            skid_instr_d = bus.imem_rdata;
            skid_pc_d    = req_pc_q;
         end else begin
            skid_valid_d = skid_valid_q;
         end
      end
   end

   // State registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         req_live_q   <= 1'b0;
         req_pc_q     <= '0;
         dec_valid_q  <= 1'b0;
         dec_instr_q  <= '0;
         dec_pc_q     <= '0;
         skid_valid_q <= 1'b0;
         skid_instr_q <= '0;
         skid_pc_q    <= '0;
         kill_ex_q    <= 1'b0;
         ovf_err_q    <= 1'b0;
      end else begin
         req_live_q   <= req_acc_s;
         req_pc_q     <= bus.pc_in;
         dec_valid_q  <= dec_valid_d;
         dec_instr_q  <= dec_instr_d;
         dec_pc_q     <= dec_pc_d;
         skid_valid_q <= skid_valid_d;
         skid_instr_q <= skid_instr_d;
         skid_pc_q    <= skid_pc_d;
         kill_ex_q    <= bus.kill_in[2];
         ovf_err_q    <= ovf_err_d;
      end
   end

   assign bus.imem_addr   = bus.pc_in;
   assign bus.dec_valid   = dec_valid_q;
   assign bus.dec_instr   = dec_instr_q;
   assign bus.dec_pc      = dec_pc_q;
   assign bus.fetch_stall = fetch_stall_s;
   assign bus.kill_ex     = kill_ex_q;
   assign bus.ovf_err     = ovf_err_q;

`ifdef FETCH_PERF_EN
   logic        kill_evt_s;
   logic [15:0] perf_stall_q, perf_kill_q;

   // A delivered (firing) out entry is not counted as discarded by a flush
   always_comb begin
      kill_evt_s = (bus.kill_in[0] & req_live_q)
                 | (bus.kill_in[1] & (skid_valid_q | (dec_valid_q & ~bus.dec_ready)));
   end

   // Saturating performance counters
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         perf_stall_q <= 16'h0000;
         perf_kill_q  <= 16'h0000;
      end else begin
         if (fetch_stall_s && (perf_stall_q != 16'hFFFF)) begin
            perf_stall_q <= perf_stall_q + 16'h0001;
         end
         if (kill_evt_s && (perf_kill_q != 16'hFFFF)) begin
            perf_kill_q <= perf_kill_q + 16'h0001;
         end
      end
   end

   assign perf_stall_cnt = perf_stall_q;
   assign perf_kill_cnt  = perf_kill_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed cycle table, async reset mid-stall, random-ready scoreboard.
module tb_fetch_stage;
   localparam int AW = 12;
   localparam int IW = 16;

   typedef struct {
      logic [AW-1:0] pc;
      logic [2:0]    kill;
      logic          pause;
      logic          rdy;
      logic          exp_dv;
      logic [AW-1:0] exp_pc;
      logic          exp_st;
      logic          exp_kex;
   } vec_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;
   vec_t tbl[$];
   logic [AW-1:0] sb_q[$];
   logic [AW-1:0] cur_pc;

   always #5 clk = ~clk;

   fetch_stage_if #(.AW(AW), .IW(IW)) bus ();

`ifdef FETCH_PERF_EN
   logic [15:0] perf_stall_cnt, perf_kill_cnt;
`endif

   fetch_stage #(.AW(AW), .IW(IW)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
`ifdef FETCH_PERF_EN
      ,
      .perf_stall_cnt (perf_stall_cnt),
      .perf_kill_cnt  (perf_kill_cnt)
`endif
   );

   // Synchronous instruction memory: word at address a is 16'hA000 + a
   always @(posedge clk) bus.imem_rdata <= 16'hA000 + {4'h0, bus.imem_addr};

   function automatic logic [IW-1:0] instr_of(input logic [AW-1:0] a);
      return 16'hA000 + {4'h0, a};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   task automatic add(input int pc, input logic [2:0] kill, input logic pause, input logic rdy,
                      input logic dv, input int epc, input logic st, input logic kex);
      vec_t v;
      v.pc = AW'(pc); v.kill = kill; v.pause = pause; v.rdy = rdy;
      v.exp_dv = dv; v.exp_pc = AW'(epc); v.exp_st = st; v.exp_kex = kex;
      tbl.push_back(v);
   endtask

   // One controller-driven cycle: compare fires against the queue, push accepted PCs
   task automatic sb_cycle(input logic rdy, input logic pause);
      logic [AW-1:0] exp_pc;
      bus.pc_in = cur_pc; bus.kill_in = 3'b000; bus.pause_in = pause; bus.dec_ready = rdy;
      @(negedge clk);
      if (bus.dec_valid && rdy) begin
         if (sb_q.size() == 0) begin
            check("sb_unexpected_instr", 32'(bus.dec_pc), 32'hFFFF_FFFF);
         end else begin
            exp_pc = sb_q.pop_front();
            check("sb_dec_pc", 32'(bus.dec_pc), 32'(exp_pc));
            check("sb_dec_instr", 32'(bus.dec_instr), 32'(instr_of(exp_pc)));
         end
      end
      if (!bus.fetch_stall && !pause) begin
         sb_q.push_back(cur_pc);
         cur_pc = cur_pc + 12'd1;
      end
      @(posedge clk); #1;
   endtask

   initial begin
      bus.pc_in = 12'd0; bus.kill_in = 3'b000; bus.pause_in = 1'b0; bus.dec_ready = 1'b1;

      //  pc  kill    pause rdy   dv  epc st  kex
      add(0,  3'b000, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
      add(1,  3'b000, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
      add(2,  3'b000, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0);
      add(3,  3'b000, 1'b0, 1'b1, 1'b1, 1, 1'b0, 1'b0);
      add(4,  3'b000, 1'b0, 1'b1, 1'b1, 2, 1'b0, 1'b0);
      add(5,  3'b000, 1'b0, 1'b1, 1'b1, 3, 1'b0, 1'b0);
      add(6,  3'b000, 1'b0, 1'b1, 1'b1, 4, 1'b0, 1'b0);
      add(7,  3'b000, 1'b0, 1'b0, 1'b1, 5, 1'b1, 1'b0);
      add(7,  3'b000, 1'b0, 1'b0, 1'b1, 5, 1'b1, 1'b0);
      add(7,  3'b000, 1'b0, 1'b0, 1'b1, 5, 1'b1, 1'b0);
      add(7,  3'b000, 1'b0, 1'b1, 1'b1, 5, 1'b1, 1'b0);
      add(7,  3'b000, 1'b0, 1'b1, 1'b1, 6, 1'b0, 1'b0);
      add(8,  3'b000, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
      add(9,  3'b001, 1'b1, 1'b1, 1'b1, 7, 1'b0, 1'b0);
      add(9,  3'b000, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
      add(10, 3'b000, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
      add(11, 3'b000, 1'b0, 1'b1, 1'b1, 9, 1'b0, 1'b0);
      add(12, 3'b000, 1'b0, 1'b0, 1'b1, 10, 1'b1, 1'b0);
      add(12, 3'b110, 1'b0, 1'b0, 1'b1, 10, 1'b1, 1'b0);
      add(0,  3'b000, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b1);
      add(1,  3'b000, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
      add(2,  3'b000, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0);
      add(3,  3'b010, 1'b0, 1'b0, 1'b1, 1, 1'b1, 1'b0);
      add(3,  3'b000, 1'b0, 1'b1, 1'b1, 2, 1'b0, 1'b0);
      add(4,  3'b000, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
      add(5,  3'b000, 1'b0, 1'b1, 1'b1, 3, 1'b0, 1'b0);
      add(6,  3'b000, 1'b0, 1'b1, 1'b1, 4, 1'b0, 1'b0);

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_dec_valid", 32'(bus.dec_valid), 32'd0);
      check("rst_fetch_stall", 32'(bus.fetch_stall), 32'd0);
      check("rst_kill_ex", 32'(bus.kill_ex), 32'd0);
      check("rst_ovf_err", 32'(bus.ovf_err), 32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         bus.pc_in = tbl[i].pc; bus.kill_in = tbl[i].kill;
         bus.pause_in = tbl[i].pause; bus.dec_ready = tbl[i].rdy;
         @(negedge clk);
         check($sformatf("row%0d_dec_valid", i), 32'(bus.dec_valid), 32'(tbl[i].exp_dv));
         check($sformatf("row%0d_fetch_stall", i), 32'(bus.fetch_stall), 32'(tbl[i].exp_st));
         check($sformatf("row%0d_kill_ex", i), 32'(bus.kill_ex), 32'(tbl[i].exp_kex));
         check($sformatf("row%0d_ovf_err", i), 32'(bus.ovf_err), 32'd0);
         if (tbl[i].exp_dv) begin
            check($sformatf("row%0d_dec_pc", i), 32'(bus.dec_pc), 32'(tbl[i].exp_pc));
            check($sformatf("row%0d_dec_instr", i), 32'(bus.dec_instr), 32'(instr_of(tbl[i].exp_pc)));
         end
         @(posedge clk); #1;
      end

`ifdef FETCH_PERF_EN
      check("perf_stall_cnt", 32'(perf_stall_cnt), 32'd7);
      check("perf_kill_cnt", 32'(perf_kill_cnt), 32'd3);
`endif

      // Fill the skid (pc 5 held, pc 6 parked), then pull reset mid-cycle
      bus.pc_in = 12'd7; bus.kill_in = 3'b000; bus.pause_in = 1'b0; bus.dec_ready = 1'b0;
      @(negedge clk);
      check("stall_before_reset", 32'(bus.fetch_stall), 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      check("skid_full_stall", 32'(bus.fetch_stall), 32'd1);
      check("skid_full_dec_pc", 32'(bus.dec_pc), 32'd5);
      #2 reset_n = 1'b0;
      #1;
      check("async_rst_dec_valid", 32'(bus.dec_valid), 32'd0);
      check("async_rst_fetch_stall", 32'(bus.fetch_stall), 32'd0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;

      cur_pc = 12'd0;
      for (int c = 0; c < 400; c++) begin
         sb_cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0));
      end
      for (int c = 0; c < 20; c++) begin
         if (sb_q.size() != 0) sb_cycle(1'b1, 1'b1);
      end
      check("sb_drained", 32'(sb_q.size()), 32'd0);
      check("sb_ovf_err", 32'(bus.ovf_err), 32'd0);

`ifdef FETCH_PERF_EN
      bus.pause_in = 1'b0; bus.dec_ready = 1'b0;
      repeat (70000) @(posedge clk);
      #1;
      check("perf_stall_saturate", 32'(perf_stall_cnt), 32'h0000_FFFF);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
